axi_mem_slave: RTL and testbench

- AXI4 responder, the memory side of the instruction cache line-fill interface.
- Serves AR/R bursts, including WRAP bursts for critical-word-first fills, from a local word-addressed RAM.
- Accepts AW/W/B bursts for program loading from the debug/loader master.
- Sits between the interconnect and on-chip block RAM. One transaction in flight at a time.

---
 rtl/axi_mem_slave_pkg.sv | 33 +++
 rtl/axi_mem_slave_addr_gen.sv | 58 +++++
 rtl/axi_mem_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_slave_pkg.sv
// Shared types and constants for the AXI4 memory responder.
//   axi_burst_t  : AXI burst encodings the responder understands
//   axi_resp_t   : AXI response encodings the responder produces
//   mem_state_t  : transaction FSM states
//   wrap_len_ok  : legal beat counts (LEN) for a WRAP burst
package axi_mem_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_BURST = 2'b01,
        WR_BURST = 2'b10,
        WR_RESP  = 2'b11
    } mem_state_t;

    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    // A WRAP burst must cover 2, 4, 8 or 16 words.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// Burst address sequencer shared by the read and write paths.
//   i_cur_addr   : address of the beat just issued
//   i_start_addr : address latched at the AR/AW handshake
//   i_len        : AXI LEN (beats - 1)
//   i_burst      : AXI BURST
//   o_next_addr  : address of the following beat
//   o_legal      : burst type / length combination is supported
module axi_mem_slave_addr_gen
    import axi_mem_slave_pkg::*;
#(
    parameter int ADDR_SIZE = 32
) (
    input  logic [ADDR_SIZE-1:0] i_cur_addr,
    input  logic [ADDR_SIZE-1:0] i_start_addr,
    input  logic [7:0]           i_len,
    input  logic [1:0]           i_burst,
    output logic [ADDR_SIZE-1:0] o_next_addr,
    output logic                 o_legal
);

    logic [ADDR_SIZE-1:0] incr_addr_s;
    logic [ADDR_SIZE-1:0] wrap_mask_s;

    // Next-address selection per burst type.
    always_comb begin
        incr_addr_s = i_cur_addr + ADDR_SIZE'(3'd4);
        // For legal WRAP lengths (LEN+1 a power of two) the byte window
        // mask (LEN+1)*4-1 is simply {LEN, 2'b11}.
        wrap_mask_s = {{(ADDR_SIZE-10){1'b0}}, i_len, 2'b11};
        o_next_addr = incr_addr_s;
        o_legal     = 1'b0;
        case (i_burst)
            FIXED: begin
                o_next_addr = i_cur_addr;
                o_legal     = 1'b1;
            end
            INCR: begin
                o_next_addr = incr_addr_s;
                o_legal     = 1'b1;
            end
            WRAP: begin
                if (wrap_len_ok(i_len)) begin
                    // Base comes from the start address; every beat stays in its window.
                    o_next_addr = (i_start_addr & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
                    o_legal     = 1'b1;
                end else begin
                    o_next_addr = incr_addr_s;
                    o_legal     = 1'b0;
                end
            end
            default: begin
                o_next_addr = incr_addr_s;
                o_legal     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder for instruction-cache line fills and program loading.
// One transaction in flight; reads have priority over writes.
//   i_aclk / i_areset_n : clock, asynchronous active-low reset
//   axi_ar*  : read address channel      axi_r* : read data channel
//   axi_aw*  : write address channel     axi_w* : write data channel
//   axi_b*   : write response channel
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    i_aclk,
    input  logic                    i_areset_n,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    input  logic [ADDR_SIZE-1:0]    axi_araddr,
    input  logic [ID_WIDTH-1:0]     axi_arid,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [ID_WIDTH-1:0]     axi_rid,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [ADDR_SIZE-1:0]    axi_awaddr,
    input  logic [ID_WIDTH-1:0]     axi_awid,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    output logic [ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]              axi_bresp
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    mem_state_t            state_q, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [ADDR_SIZE-1:0]  start_q, start_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic [2:0]            size_q, size_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  berr_q, berr_d;

    logic [ADDR_SIZE-1:0]  next_addr_s;
    logic                  burst_legal_s;
    logic                  txn_ok_s;
    logic                  size_ok_s;
    logic                  last_beat_s;
    logic                  all_issued_s;
    logic                  ram_ren_s;
    logic                  ram_wen_s;
    logic [IDX_W-1:0]      ram_idx_s;

    axi_mem_slave_addr_gen #(
        .ADDR_SIZE(ADDR_SIZE)
    ) u_addr_gen (
        .i_cur_addr  (addr_q),
        .i_start_addr(start_q),
        .i_len       (len_q),
        .i_burst     (burst_q),
        .o_next_addr (next_addr_s),
        .o_legal     (burst_legal_s)
    );

    // Upper address bits alias onto the word-addressed RAM.
    assign ram_idx_s    = addr_q[2 +: IDX_W];
    assign size_ok_s    = (size_q == AXI_SIZE_WORD);
    assign txn_ok_s     = burst_legal_s & size_ok_s;
    assign last_beat_s  = (cnt_q == {1'b0, len_q});
    assign all_issued_s = (cnt_q == ({1'b0, len_q} + 9'd1));

    // Transaction FSM: next state, latched burst fields and RAM strobes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_d   = start_q;
        len_d     = len_q;
        burst_d   = burst_q;
        size_d    = size_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        berr_d    = berr_q;
        ram_ren_s = 1'b0;
        ram_wen_s = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = 9'd0;
                rlast_d = 1'b0;
                berr_d  = 1'b0;
                if (axi_arvalid) begin
                    addr_d  = axi_araddr;
                    start_d = axi_araddr;
                    len_d   = axi_arlen;
                    burst_d = axi_arburst;
                    size_d  = axi_arsize;
                    id_d    = axi_arid;
                    state_d = RD_BURST;
                end else if (axi_awvalid) begin
                    addr_d  = axi_awaddr;
                    start_d = axi_awaddr;
                    len_d   = axi_awlen;
                    burst_d = axi_awburst;
                    size_d  = axi_awsize;
                    id_d    = axi_awid;
                    state_d = WR_BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                // The RAM output register is the R stage: a new word is only
                // fetched when that stage is empty or being consumed, so a
                // stalled beat holds and the address does not move.
                if (!rvalid_q || axi_rready) begin
                    if (!all_issued_s) begin
                        ram_ren_s = 1'b1;
                        addr_d    = next_addr_s;
                        cnt_d     = cnt_q + 9'd1;
                        rvalid_d  = 1'b1;
                        rlast_d   = last_beat_s;
                    end else begin
                        rvalid_d  = 1'b0;
                    end
                end else begin
                    rvalid_d = rvalid_q;
                end
                if (rvalid_q && axi_rready && rlast_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (axi_wvalid) begin
                    ram_wen_s = size_ok_s;
                    addr_d    = next_addr_s;
                    cnt_d     = cnt_q + 9'd1;
                    if (axi_wlast || last_beat_s) begin
                        // Early WLAST or missing WLAST both end the burst with an error.
                        berr_d  = (axi_wlast != last_beat_s) | ~txn_ok_s;
                        state_d = WR_RESP;
                    end else begin
                        state_d = WR_BURST;
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            WR_RESP: begin
                if (axi_bready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and burst-context registers.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            start_q  <= '0;
            len_q    <= 8'd0;
            burst_q  <= 2'b00;
            size_q   <= 3'b000;
            id_q     <= '0;
            cnt_q    <= 9'd0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            size_q   <= size_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            berr_q   <= berr_d;
        end
    end

    // RAM byte-enable write port; contents survive reset.
    always_ff @(posedge i_aclk) begin
        if (ram_wen_s) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (axi_wstrb[b]) begin
                    mem[ram_idx_s][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // RAM registered read port, doubling as the R output stage.
    always_ff @(posedge i_aclk) begin
        if (ram_ren_s) begin
            rdata_q <= mem[ram_idx_s];
        end
    end

    // Ready strobes are gated by reset so they stay low while it is asserted.
    assign axi_arready = i_areset_n & (state_q == IDLE);
    assign axi_awready = i_areset_n & (state_q == IDLE) & ~axi_arvalid;
    assign axi_wready  = (state_q == WR_BURST);

    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = (rvalid_q && txn_ok_s) ? rdata_q : '0;
    assign axi_rresp   = (rvalid_q && !txn_ok_s) ? SLVERR : OKAY;
    assign axi_rlast   = rvalid_q & rlast_q;
    assign axi_rid     = rvalid_q ? id_q : '0;

    assign axi_bvalid  = (state_q == WR_RESP);
    assign axi_bresp   = ((state_q == WR_RESP) && berr_q) ? SLVERR : OKAY;
    assign axi_bid     = (state_q == WR_RESP) ? id_q : '0;

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;

    localparam int MEM_DEPTH = 4096;
    localparam int BUDGET    = 3000;

    logic        aclk;
    logic        rst_n;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    axi_mem_slave dut (
        .i_aclk(aclk), .i_areset_n(rst_n),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arid(arid),
        .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rid(rid),
        .axi_rresp(rresp), .axi_rlast(rlast),
        .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awid(awid),
        .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_wlast(wlast),
        .axi_bvalid(bvalid), .axi_bready(bready), .axi_bid(bid), .axi_bresp(bresp)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [31:0] model [MEM_DEPTH];
    logic [31:0] w_data_tbl [256];
    logic [3:0]  w_strb_tbl [256];
    int          n_cmp;
    int          n_fail;
    int          r_seen;
    int          rr_mode;
    time         rlast_time;
    time         aw_hs_time;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference address of beat i of a legal burst, straight from the AXI rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] bound;
        logic [31:0] base;
        case (burst)
            2'b00: return start;
            2'b10: begin
                bound = (32'(len) + 32'd1) * 32'd4;
                base  = start - (start % bound);
                return base + (((start - base) + 32'(i) * 32'd4) % bound);
            end
            default: return start + 32'(i) * 32'd4;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % MEM_DEPTH);
    endfunction

    function automatic bit legal_txn(input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
        if (size != 3'b010) return 1'b0;
        if (burst == 2'b00 || burst == 2'b01) return 1'b1;
        if (burst == 2'b10) return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return 1'b0;
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        bit          ok;
        bit          got;
        logic [31:0] a;
        ok = legal_txn(len, burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, burst, i);
            rq.push_back('{data: ok ? model[idx_of(a)] : 32'h0, resp: ok ? 2'b00 : 2'b10,
                           last: (i == int'(len)), id: id});
        end
        @(posedge aclk); #1;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size;
        got = 1'b0;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(negedge aclk);
            if (arready) got = 1'b1;
        end
        check(got, "ar_accept", 64'(got), 64'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int early, input bit gaps);
        int          nb;
        bit          ok;
        bit          got;
        logic [31:0] a;
        nb = (early >= 0) ? early + 1 : int'(len) + 1;
        ok = legal_txn(len, burst, size) && (early < 0 || early == int'(len));
        bq.push_back('{resp: ok ? 2'b00 : 2'b10, id: id});
        @(posedge aclk); #1;
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size;
        got = 1'b0;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(negedge aclk);
            if (awready) got = 1'b1;
        end
        aw_hs_time = $time;
        check(got, "aw_accept", 64'(got), 64'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge aclk); #1;
            end
            wvalid = 1'b1; wdata = w_data_tbl[i]; wstrb = w_strb_tbl[i]; wlast = (i == nb - 1);
            got = 1'b0;
            for (int c = 0; c < BUDGET && !got; c++) begin
                @(negedge aclk);
                if (wready) got = 1'b1;
            end
            if (!got) check(got, "w_accept", 64'(got), 64'd1);
            @(posedge aclk); #1;
            wvalid = 1'b0; wlast = 1'b0;
            if (size == 3'b010) begin
                a = beat_addr(addr, len, burst, i);
                for (int b = 0; b < 4; b++) begin
                    if (w_strb_tbl[i][b]) model[idx_of(a)][8*b +: 8] = w_data_tbl[i][8*b +: 8];
                end
            end
        end
    endtask

    task automatic drain;
        bit done;
        done = 1'b0;
        for (int c = 0; c < BUDGET && !done; c++) begin
            @(negedge aclk);
            if (rq.size() == 0 && bq.size() == 0) done = 1'b1;
        end
        check(done, "drain", 64'(rq.size() + bq.size()), 64'd0);
    endtask

    // R/B ready drivers: always-on, random, or the 1,0,0,1 stall pattern.
    initial begin
        int k;
        int prev;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        prev = 0;
        rready = 1'b0;
        bready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (rr_mode != prev) k = 0;
            prev = rr_mode;
            case (rr_mode)
                0: rready = 1'b1;
                1: rready = 1'($urandom_range(0, 1));
                default: begin
                    rready = pat[k];
                    k = (k + 1) % 4;
                end
            endcase
            bready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every R or B handshake pops and checks the oldest expectation.
    initial begin
        r_exp_t re;
        b_exp_t be;
        forever begin
            @(negedge aclk);
            if (rst_n) begin
                if (rvalid && rready) begin
                    r_seen++;
                    if (rq.size() == 0) begin
                        check(1'b0, "r_unexpected", 64'(rdata), 64'd0);
                    end else begin
                        re = rq.pop_front();
                        check({rdata, rresp, rlast, rid} === {re.data, re.resp, re.last, re.id}, "r_beat",
                              64'({rdata, rresp, rlast, rid}), 64'({re.data, re.resp, re.last, re.id}));
                    end
                    if (rlast) rlast_time = $time;
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        check(1'b0, "b_unexpected", 64'(bresp), 64'd0);
                    end else begin
                        be = bq.pop_front();
                        check({bresp, bid} === {be.resp, be.id}, "b_resp",
                              64'({bresp, bid}), 64'({be.resp, be.id}));
                    end
                end
            end
        end
    end

    initial begin
        int          base;
        bit          got;
        logic [1:0]  b;
        logic [7:0]  l;
        logic [2:0]  sz;
        int          early;
        n_cmp = 0; n_fail = 0; r_seen = 0; rr_mode = 0;
        rlast_time = 0; aw_hs_time = 0;
        rst_n = 1'b0;
        arvalid = 1'b0; araddr = 32'h0; arid = 4'h0; arlen = 8'h0; arsize = 3'b010; arburst = 2'b01;
        awvalid = 1'b0; awaddr = 32'h0; awid = 4'h0; awlen = 8'h0; awsize = 3'b010; awburst = 2'b01;
        wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) model[i] = 32'h0;

        // Reset state and first cycle after release.
        repeat (3) @(negedge aclk);
        check({arready, awready, rvalid, rdata, rresp, rlast, rid, wready, bvalid, bresp, bid} == 51'd0,
              "reset_outputs", 64'({arready, awready, rvalid, rdata, rresp, rlast, rid, wready, bvalid, bresp, bid}), 64'd0);
        @(posedge aclk); #3;
        rst_n = 1'b1;
        @(negedge aclk);
        check({arready, awready} == 2'b11, "ready_after_reset", 64'({arready, awready}), 64'd3);

        // Preload mem[i] = i through AXI.
        for (int blk = 0; blk < MEM_DEPTH / 256; blk++) begin
            for (int i = 0; i < 256; i++) begin
                w_data_tbl[i] = 32'(blk * 256 + i);
                w_strb_tbl[i] = 4'hF;
            end
            do_write(32'(blk * 1024), 4'(blk), 8'd255, 2'b01, 3'b010, -1, 1'b0);
        end
        drain();

        // Single beat read with first-beat latency.
        do_read(32'h10, 4'd3, 8'd0, 2'b01, 3'b010);
        @(negedge aclk);
        check(rvalid == 1'b0, "rvalid_cycle1", 64'(rvalid), 64'd0);
        @(negedge aclk);
        check(rvalid == 1'b1, "rvalid_cycle2", 64'(rvalid), 64'd1);
        drain();

        // Critical-word-first wrap fill: 14,15,8..13.
        do_read(32'h38, 4'd1, 8'd7, 2'b10, 3'b010);
        drain();

        // Backpressure 1,0,0,1.
        rr_mode = 2;
        do_read(32'h0, 4'd2, 8'd3, 2'b01, 3'b010);
        drain();
        rr_mode = 0;

        // Write with strobes then read back.
        w_data_tbl[0] = 32'hFFFF_FFFF; w_strb_tbl[0] = 4'hF;
        w_data_tbl[1] = 32'hFFFF_FFFF; w_strb_tbl[1] = 4'hF;
        do_write(32'h100, 4'd4, 8'd1, 2'b01, 3'b010, -1, 1'b0);
        w_data_tbl[0] = 32'hDEAD_BEEF; w_strb_tbl[0] = 4'b1111;
        w_data_tbl[1] = 32'h1234_5678; w_strb_tbl[1] = 4'b0011;
        do_write(32'h100, 4'd5, 8'd1, 2'b01, 3'b010, -1, 1'b0);
        do_read(32'h100, 4'd6, 8'd1, 2'b01, 3'b010);
        drain();
        check(model[64] == 32'hDEAD_BEEF && model[65] == 32'hFFFF_5678, "model_strobe",
              64'({model[64], model[65]}), 64'hDEADBEEF_FFFF5678);

        // Simultaneous AR and AW: read first, AW after RLAST.
        w_data_tbl[0] = 32'hA5A5_0001; w_strb_tbl[0] = 4'hF;
        w_data_tbl[1] = 32'hA5A5_0002; w_strb_tbl[1] = 4'hF;
        fork
            do_read(32'h200, 4'd7, 8'd3, 2'b01, 3'b010);
            do_write(32'h300, 4'd8, 8'd1, 2'b01, 3'b010, -1, 1'b0);
            begin
                @(posedge aclk); @(negedge aclk);
                check(arready && !awready, "collision_ready", 64'({arready, awready}), 64'd2);
            end
        join
        drain();
        check(aw_hs_time > rlast_time, "aw_after_rlast", 64'(aw_hs_time), 64'(rlast_time));

        // Illegal size read, FIXED bursts, early WLAST, index wrap-around.
        do_read(32'h80, 4'd9, 8'd2, 2'b01, 3'b001);
        for (int i = 0; i < 3; i++) begin
            w_data_tbl[i] = 32'hC0DE_0000 + 32'(i); w_strb_tbl[i] = 4'hF;
        end
        do_write(32'h500, 4'd10, 8'd2, 2'b00, 3'b010, -1, 1'b1);
        do_read(32'h500, 4'd11, 8'd2, 2'b00, 3'b010);
        do_write(32'h600, 4'd12, 8'd3, 2'b01, 3'b010, 1, 1'b0);
        do_read(32'h600, 4'd13, 8'd3, 2'b01, 3'b010);
        do_read(32'h3FF8, 4'd14, 8'd3, 2'b01, 3'b010);
        do_read(32'h44, 4'd15, 8'd5, 2'b10, 3'b010);
        drain();

        // Reset during beat 2 of an 8-beat read.
        base = r_seen;
        do_read(32'h40, 4'd5, 8'd7, 2'b01, 3'b010);
        got = 1'b0;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(posedge aclk);
            if (r_seen >= base + 2) got = 1'b1;
        end
        check(got, "mid_read_beats", 64'(r_seen - base), 64'd2);
        #3;
        rst_n = 1'b0;
        rq.delete();
        #1;
        check({rvalid, arready, awready} == 3'b000, "reset_abort", 64'({rvalid, arready, awready}), 64'd0);
        repeat (2) @(posedge aclk);
        #3;
        rst_n = 1'b1;
        @(negedge aclk);
        check({arready, awready} == 2'b11, "ready_after_abort", 64'({arready, awready}), 64'd3);
        do_read(32'h40, 4'd6, 8'd3, 2'b01, 3'b010);
        drain();

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            rr_mode = t % 2;
            if ($urandom_range(0, 1) == 1) begin
                b = 2'($urandom_range(0, 3));
                if (b == 2'b10) l = ($urandom_range(0, 7) == 0) ? 8'd5 : 8'((1 << $urandom_range(1, 4)) - 1);
                else l = 8'($urandom_range(0, 15));
                sz = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
                do_read($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), l, b, sz);
            end else begin
                b = 2'($urandom_range(0, 2));
                if (b == 2'b10) l = 8'((1 << $urandom_range(1, 4)) - 1);
                else l = 8'($urandom_range(0, 15));
                sz = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
                early = (l > 8'd0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, int'(l) - 1) : -1;
                for (int i = 0; i < 16; i++) begin
                    w_data_tbl[i] = $urandom;
                    w_strb_tbl[i] = 4'($urandom_range(0, 15));
                end
                do_write($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), l, b, sz, early, 1'b1);
            end
        end
        drain();
        rr_mode = 0;
        repeat (4) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
